// File: rtl/key_scan_ctrl.sv
// Keypad front end: 2-flop synchroniser, priority encoder (key 9 highest),
// press/release debounce FSM and a single-entry valid/ready event register.
module key_scan_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 20,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  S_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        key_down,
  output logic        overrun,
  input  logic        clr_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    DB_RELEASE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [9:0]       s_meta_q, s_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             down_q, down_d;
  logic             ovr_q, ovr_d;

  logic [3:0]       code;
  logic             any;
  logic             fire;
  logic             accept;
  logic             ovr_set;

  // Ascending scan so the highest pressed index overwrites lower ones.
  always_comb begin
    code = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (!s_sync_q[i]) code = 4'(i);
    end
    any = ~&s_sync_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    down_d  = down_q;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          cand_d  = code;
          cnt_d   = '0;
          state_d = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (!any) begin
          state_d = IDLE;
        end else if (code != cand_q) begin
          cand_d = code;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          down_d  = 1'b1;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!any || code != cand_q) begin
          cnt_d   = '0;
          state_d = DB_RELEASE;
        end
      end
      DB_RELEASE: begin
        // Any other key here is treated as a release; it is picked up from IDLE.
        if (any && code == cand_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          down_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept  = valid_q & key_ready;
    valid_d = valid_q;
    code_d  = code_q;
    ovr_set = 1'b0;
    if (accept) valid_d = 1'b0;
    // A consumer pop on the same edge frees the slot for the new event.
    if (fire) begin
      if (!valid_q || accept) begin
        code_d  = cand_q;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end
    if (ovr_set)          ovr_d = 1'b1;
    else if (clr_overrun) ovr_d = 1'b0;
    else                  ovr_d = ovr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta_q <= '1;
      s_sync_q <= '1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      down_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      s_meta_q <= S_n;
      s_sync_q <= s_meta_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      down_q   <= down_d;
      ovr_q    <= ovr_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Bench for key_scan_ctrl with a short debounce: expected key codes are queued
// when a press is driven and popped when the consumer takes an event.
module tb_key_scan_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned LAT = DB + 2;

  logic       clk;
  logic       rst;
  logic [9:0] S_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_down;
  logic       overrun;
  logic       clr_overrun;

  int n_chk;
  int n_fail;
  logic [3:0] sb[$];

  key_scan_ctrl #(.DEBOUNCE_CYC(DB), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .S_n         (S_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_down    (key_down),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Consumer side: an event transfers on the edge following valid & ready.
  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_event", 32'(sb.size()), 32'(1));
      end else begin
        check_eq("sb_code", 32'(key_code), 32'(sb.pop_front()));
      end
    end
  end

  task automatic press_expect(input logic [9:0] sn, input logic [3:0] code);
    S_n = sn;
    sb.push_back(code);
    repeat (LAT) begin
      tick();
      check_eq("press_wait_valid", 32'(key_valid), 32'(0));
      check_eq("press_wait_down", 32'(key_down), 32'(0));
    end
    tick();
    check_eq("press_valid", 32'(key_valid), 32'(1));
    check_eq("press_down", 32'(key_down), 32'(1));
    check_eq("press_code", 32'(key_code), 32'(code));
  endtask

  task automatic release_expect;
    S_n = '1;
    repeat (LAT) begin
      tick();
      check_eq("release_wait_down", 32'(key_down), 32'(1));
    end
    tick();
    check_eq("release_down", 32'(key_down), 32'(0));
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    S_n         = '1;
    key_ready   = 1'b0;
    clr_overrun = 1'b0;

    // 1: reset with toggling keys
    for (int i = 0; i < 3; i++) begin
      S_n = 10'($urandom);
      tick();
      check_eq("rst_valid", 32'(key_valid), 32'(0));
      check_eq("rst_down", 32'(key_down), 32'(0));
      check_eq("rst_code", 32'(key_code), 32'(0));
      check_eq("rst_overrun", 32'(overrun), 32'(0));
    end
    S_n = '1;
    rst = 1'b0;
    repeat (3) tick();

    // 2: clean press/release of key 3
    key_ready = 1'b1;
    press_expect(10'h3F7, 4'd3);
    tick();
    check_eq("accept_clears_valid", 32'(key_valid), 32'(0));
    repeat (12) tick();
    check_eq("held_down", 32'(key_down), 32'(1));
    release_expect();

    // 3: bounce shorter than debounce
    S_n = 10'h3DF;
    repeat (3) begin
      tick();
      check_eq("bounce_valid", 32'(key_valid), 32'(0));
    end
    S_n = '1;
    repeat (8) begin
      tick();
      check_eq("bounce_valid", 32'(key_valid), 32'(0));
      check_eq("bounce_down", 32'(key_down), 32'(0));
    end

    // 4: keys 0 and 9 together, then drop key 9
    press_expect(10'h1FE, 4'd9);
    tick();
    check_eq("k9_accepted", 32'(key_valid), 32'(0));
    S_n = 10'h3FE;
    repeat (LAT) begin
      tick();
      check_eq("swap_wait_down", 32'(key_down), 32'(1));
      check_eq("swap_no_event", 32'(key_valid), 32'(0));
    end
    tick();
    check_eq("swap_down_fall", 32'(key_down), 32'(0));
    S_n = '1;
    repeat (10) begin
      tick();
      check_eq("swap_after_valid", 32'(key_valid), 32'(0));
      check_eq("swap_after_down", 32'(key_down), 32'(0));
    end

    // 5: overrun with stalled consumer
    key_ready = 1'b0;
    press_expect(10'h3FD, 4'd1);
    release_expect();
    check_eq("stall_valid", 32'(key_valid), 32'(1));
    S_n = 10'h3FB;
    repeat (LAT) begin
      tick();
      check_eq("ovr_wait", 32'(overrun), 32'(0));
    end
    tick();
    check_eq("ovr_set", 32'(overrun), 32'(1));
    check_eq("ovr_code_kept", 32'(key_code), 32'(1));
    check_eq("ovr_valid", 32'(key_valid), 32'(1));
    check_eq("ovr_down", 32'(key_down), 32'(1));
    key_ready = 1'b1;
    tick();
    check_eq("ovr_drained", 32'(key_valid), 32'(0));
    check_eq("ovr_sticky", 32'(overrun), 32'(1));
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check_eq("ovr_cleared", 32'(overrun), 32'(0));
    release_expect();

    // 6a: reset mid-debounce, key still held afterwards
    S_n = 10'h3EF;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check_eq("rst_db_valid", 32'(key_valid), 32'(0));
    check_eq("rst_db_down", 32'(key_down), 32'(0));
    repeat (2) tick();
    key_ready = 1'b0;
    rst = 1'b0;
    press_expect(10'h3EF, 4'd4);

    // 6b: reset with an event pending
    rst = 1'b1;
    #1;
    check_eq("rst_pend_valid", 32'(key_valid), 32'(0));
    check_eq("rst_pend_code", 32'(key_code), 32'(0));
    sb.delete();
    repeat (2) tick();
    key_ready = 1'b1;
    rst = 1'b0;
    press_expect(10'h3EF, 4'd4);
    release_expect();
    repeat (2) tick();
    check_eq("sb_drain", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit %0t", $time);
    $fatal(1);
  end

endmodule
